// File: rtl/search_pkg.sv
// Shared constants and state encoding for the collision-search command loader.
package search_pkg;
    localparam logic [7:0]  OP_SEARCH  = 8'h01;
    localparam logic [31:0] ST_FOUND   = 32'h0000_0001;
    localparam logic [31:0] ST_TIMEOUT = 32'h0000_0002;
    localparam logic [31:0] ST_BAD_OP  = 32'hFFFF_FFFF;
    localparam int          MSG_WORDS  = 16;

    typedef enum logic [3:0] {
        S_HDR, S_MSG, S_CNT, S_INC, S_START, S_BUSY,
        S_RESP0, S_RESP1, S_RESP2, S_ERR
    } loader_state_t;
endpackage

// File: rtl/search_timeout_counter.sv
// Busy-cycle counter for the loader; expired is asserted while enabled and the count equals LIMIT.
module search_timeout_counter #(
    parameter logic [31:0] LIMIT = 32'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [31:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 32'd1;
    end

    assign expired = enable && (count == LIMIT);
endmodule

// File: rtl/search_command_loader.sv
// Framed command loader in front of one collision searcher.
// Optional busy timeout with abort is built only when SEARCH_TIMEOUT_EN is defined.
module search_command_loader
    import search_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         srch_start,
    output logic [4:0]   srch_target,
    output logic [511:0] srch_message,
    output logic [31:0]  srch_counter,
    output logic [31:0]  srch_increment,
    input  logic         srch_done,
    input  logic [31:0]  srch_result,
    input  logic [31:0]  srch_digests,
    output logic         srch_abort
);
    loader_state_t state;
    logic [3:0]    msgIdx;
    logic [31:0]   resultReg, digestReg;
    logic          inXfer, outXfer, timeoutHit;

    // Gated by reset so the host sees not-ready while reset is held.
    assign in_ready = !reset && (state inside {S_HDR, S_MSG, S_CNT, S_INC});
    assign inXfer   = in_valid && in_ready;
    assign outXfer  = out_valid && out_ready;

`ifdef SEARCH_TIMEOUT_EN
    search_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_START),
        .enable  (state == S_BUSY),
        .expired (timeoutHit)
    );
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_HDR;
            msgIdx         <= '0;
            resultReg      <= '0;
            digestReg      <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            srch_start     <= 1'b0;
            srch_abort     <= 1'b0;
            srch_target    <= '0;
            srch_message   <= '0;
            srch_counter   <= '0;
            srch_increment <= '0;
        end else begin
            srch_start <= 1'b0;
            srch_abort <= 1'b0;
            case (state)
                S_HDR: if (inXfer) begin
                    if (in_data[31:24] == OP_SEARCH) begin
                        srch_target <= in_data[4:0];
                        msgIdx      <= '0;
                        state       <= S_MSG;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= ST_BAD_OP;
                        state     <= S_ERR;
                    end
                end
                S_MSG: if (inXfer) begin
                    // Word index i lands at bits [511-32*i -: 32]; ~i == 15-i for a 4-bit index.
                    srch_message[{~msgIdx, 5'd0} +: 32] <= in_data;
                    msgIdx <= msgIdx + 4'd1;
                    if (msgIdx == 4'(MSG_WORDS - 1)) state <= S_CNT;
                end
                S_CNT: if (inXfer) begin
                    srch_counter <= in_data;
                    state        <= S_INC;
                end
                S_INC: if (inXfer) begin
                    srch_increment <= in_data;
                    srch_start     <= 1'b1;
                    state          <= S_START;
                end
                S_START: state <= S_BUSY;
                S_BUSY: begin
                    // A done in the same cycle as the timeout takes priority.
                    if (srch_done || timeoutHit) begin
                        resultReg <= srch_result;
                        digestReg <= srch_digests;
                        out_valid <= 1'b1;
                        out_data  <= srch_done ? ST_FOUND : ST_TIMEOUT;
                        srch_abort <= !srch_done;
                        state     <= S_RESP0;
                    end
                end
                S_RESP0: if (outXfer) begin
                    out_data <= resultReg;
                    state    <= S_RESP1;
                end
                S_RESP1: if (outXfer) begin
                    out_data <= digestReg;
                    state    <= S_RESP2;
                end
                S_RESP2, S_ERR: if (outXfer) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    state     <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule
